adder_share_arbiter: RTL

//  Shares one WIDTH-bit ripple adder (add_4bit) between two requesters.

---
 rtl/adder_share_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Shares one WIDTH-bit adder between two requesters with round-robin arbitration.
// Latency: rsp_valid rises ADD_LAT cycles after the accept edge; one op per ADD_LAT+2 cycles.
// Backpressure: the result is held in RESP until rsp_ready; no request is accepted outside IDLE.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req{0,1}_valid/_ready    request handshake per requester
//   req{0,1}_a/_b            operands for each requester
//   rsp_valid/_ready         result handshake
//   rsp_sum                  registered sum, MSB is the carry out
//   rsp_id                   requester that owns rsp_sum
//   add_a/add_b/add_sum      connection to the shared external adder
module adder_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1   // 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_sum,
  output logic             rsp_id,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(ADD_LAT);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH:0]   rsp_sum_q, rsp_sum_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;

  // Winner selection: a lone requester wins outright; on contention the
  // requester named by prio wins. With only req1 valid this yields 1, with
  // only req0 valid it yields 0.
  logic grant_any;
  logic winner;

  always_comb begin
    grant_any = (state_q == IDLE) && (req0_valid || req1_valid);
    winner    = (req0_valid && req1_valid) ? prio_q : req1_valid;
  end

  // State register (all architectural state lives here).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= 4'd0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          add_a_d  = winner ? req1_a : req0_a;
          add_b_d  = winner ? req1_b : req0_b;
          rsp_id_d = winner;
          cnt_d    = LAT_INIT;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // Operands stay put; the adder output is sampled on the last count.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_sum_d   = add_sum;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          prio_d      = ~rsp_id_q;  // the other requester gets priority next
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Ready is gated by rst so it is low for the whole reset pulse,
  // including any combinational path from valid while the flops are held.
  always_comb begin
    req0_ready = !rst && grant_any && !winner;
    req1_ready = !rst && grant_any &&  winner;
    rsp_valid  = rsp_valid_q;
    rsp_sum    = rsp_sum_q;
    rsp_id     = rsp_id_q;
    add_a      = add_a_q;
    add_b      = add_b_q;
  end

endmodule
